// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit (plus the pipes package that carries alu_func_t)
// Purpose  : Iterative RV64M multiply/divide for the execute stage. It does
//            one shift-add or restoring-divide step per cycle. Divide-by-zero
//            and signed overflow are resolved at accept time.
// Revision : 1.0 - initial release
// ============================================================================

package pipes;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_MULT, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_func_t;
endpackage

module muldiv_unit
  import pipes::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  alu_func_t       alufunc,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              c_HALF   = XLEN / 2;
  localparam int              c_CW     = $clog2(XLEN) + 1;
  localparam logic [c_CW-1:0] c_N_FULL = c_CW'(XLEN);
  localparam logic [c_CW-1:0] c_N_WORD = c_CW'(c_HALF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  alu_func_t       r_func;
  logic            r_word;
  logic            r_negq;
  logic            r_negr;
  logic [XLEN-1:0] r_acc;     // product accumulator / partial remainder
  logic [XLEN-1:0] r_x;       // multiplier / dividend-quotient shifter
  logic [XLEN-1:0] r_y;       // multiplicand / divisor magnitude
  logic [XLEN-1:0] r_result;
  logic            r_done;

  assign ready  = (r_state == S_IDLE);
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;

  // ---------------- request decode and operand preparation ----------------
  logic            w_md_op, w_signed, w_div, w_is_rem, w_accept;
  logic            w_a_neg, w_b_neg, w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_a_sx, w_b_sx, w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min;
  logic [XLEN-1:0] w_sp_result;

  assign w_md_op  = alufunc inside {ALU_MULT, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign w_signed = (alufunc == ALU_DIV) || (alufunc == ALU_REM);
  assign w_div    = w_md_op && (alufunc != ALU_MULT);
  assign w_is_rem = (alufunc == ALU_REM) || (alufunc == ALU_REMU);
  assign w_accept = valid && ready && !flush && w_md_op;

  assign w_a_sx  = {{c_HALF{a[c_HALF-1]}}, a[c_HALF-1:0]};
  assign w_b_sx  = {{c_HALF{b[c_HALF-1]}}, b[c_HALF-1:0]};
  assign w_a_ext = !word ? a : (w_signed ? w_a_sx : {{c_HALF{1'b0}}, a[c_HALF-1:0]});
  assign w_b_ext = !word ? b : (w_signed ? w_b_sx : {{c_HALF{1'b0}}, b[c_HALF-1:0]});
  assign w_a_neg = w_signed && w_a_ext[XLEN-1];
  assign w_b_neg = w_signed && w_b_ext[XLEN-1];
  assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

  // Most-negative value of the active width, sign-extended to XLEN.
  assign w_min = word ? {{(c_HALF + 1){1'b1}}, {(c_HALF - 1){1'b0}}}
                      : {1'b1, {(XLEN - 1){1'b0}}};

  assign w_div0    = w_div && (w_b_ext == '0);
  assign w_ovf     = w_signed && (w_a_ext == w_min) && (&w_b_ext);
  assign w_special = w_div0 || w_ovf;

  // Results that need no iteration. For the extended operands, the word-mode
  // sign extension is already in place.
  always_comb begin
    w_sp_result = '0;
    if (w_div0) begin
      if (w_is_rem) w_sp_result = word ? w_a_sx : a;
      else          w_sp_result = '1;
    end else if (w_ovf) begin
      w_sp_result = w_is_rem ? '0 : w_a_ext;
    end
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_acc_n, w_x_n, w_y_n, w_q, w_r, w_raw, w_fin;

  assign w_shift = {r_acc, r_x[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_y};
  assign w_ge    = !w_diff[XLEN];

  // Shift-add multiply step, or restoring-divide step, selected by latched op.
  always_comb begin
    w_acc_n = r_acc;
    w_x_n   = r_x;
    w_y_n   = r_y;
    if (r_func == ALU_MULT) begin
      w_acc_n = r_acc + (r_x[0] ? r_y : '0);
      w_x_n   = r_x >> 1;
      w_y_n   = r_y << 1;
    end else begin
      w_acc_n = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      w_x_n   = {r_x[XLEN-2:0], w_ge};
    end
  end

  // Sign fix-up and word-mode sign extension for the last iteration.
  always_comb begin
    w_q   = r_negq ? -w_x_n : w_x_n;
    w_r   = r_negr ? -w_acc_n : w_acc_n;
    w_raw = w_q;
    if (r_func == ALU_MULT)                             w_raw = w_acc_n;
    else if ((r_func == ALU_REM) || (r_func == ALU_REMU)) w_raw = w_r;
    w_fin = r_word ? {{c_HALF{w_raw[c_HALF-1]}}, w_raw[c_HALF-1:0]} : w_raw;
  end

  // Control FSM plus datapath registers. done is a one-cycle registered pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_func   <= ALU_ADD;
      r_word   <= 1'b0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_func <= alufunc;
            r_word <= word;
            if (w_special) begin
              r_result <= w_sp_result;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= word ? c_N_WORD : c_N_FULL;
              r_acc   <= '0;
              if (w_div) begin
                // Left-justify a word dividend so the MSB-first loop sees it.
                r_x    <= word ? {w_a_mag[c_HALF-1:0], {c_HALF{1'b0}}} : w_a_mag;
                r_y    <= w_b_mag;
                r_negq <= w_a_neg ^ w_b_neg;
                r_negr <= w_a_neg;
              end else begin
                r_x    <= w_a_ext;
                r_y    <= w_b_ext;
                r_negq <= 1'b0;
                r_negr <= 1'b0;
              end
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_acc_n;
            r_x   <= w_x_n;
            r_y   <= w_y_n;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == c_CW'(1)) begin
              r_result <= w_fin;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Scoreboard bench for muldiv_unit. It uses directed vectors with
//            hand-computed results and done-cycle expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset, valid, word, flush;
  alu_func_t   alufunc;
  logic [63:0] a, b;
  logic        ready, busy, done;
  logic [63:0] result;

  muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .valid(valid), .alufunc(alufunc), .word(word),
    .a(a), .b(b), .flush(flush), .ready(ready), .busy(busy), .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          done_seen = 0;
  logic [63:0] last_exp = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h expected=no_done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (result !== e.res) begin
          failures++;
          $display("FAIL %s_result actual=%h expected=%h", e.nm, result, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL %s_latency actual_cycle=%0d expected_cycle=%0d", e.nm, cyc, e.cyc);
        end
      end
    end
  end

  // Issue one request when the unit is idle. lat is the number of edges after
  // the accept edge until done is visible: N for iterative ops (done in cycle
  // N+1 after accept), 0 for special cases (done in the first cycle).
  task automatic issue(input alu_func_t f, input logic w, input logic [63:0] aa,
                       input logic [63:0] bb, input logic [63:0] exp, input int lat,
                       input bit push, input string nm);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout actual=busy expected=ready", nm);
      return;
    end
    if (push) begin
      sb.push_back('{res: exp, cyc: cyc + 1 + lat, nm: nm});
      last_exp = exp;
    end
    alufunc = f; word = w; a = aa; b = bb; valid = 1'b1;
    @(negedge clk);
    // Scramble the inputs so the unit must work from its latched copies.
    valid = 1'b0; alufunc = ALU_ADD; word = ~w; a = ~aa; b = 64'h0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((sb.size() != 0 || !ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    reset = 1'b1; valid = 1'b0; flush = 1'b0; word = 1'b0;
    alufunc = ALU_ADD; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  64'(ready),  64'd1);
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_done",   64'(done),   64'd0);
    chk("rst_result", result,      64'd0);
    reset = 1'b0;

    // A non-M function is never accepted.
    @(negedge clk);
    valid = 1'b1; alufunc = ALU_ADD; a = 64'd1; b = 64'd2;
    @(negedge clk);
    chk("nonm_ready", 64'(ready), 64'd1);
    chk("nonm_busy",  64'(busy),  64'd0);
    valid = 1'b0;

    issue(ALU_MULT, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 1, "mul_7_m3");
    issue(ALU_DIV,  0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1, "div_m20_6");
    issue(ALU_REM,  0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1, "rem_m20_6");
    issue(ALU_DIV,  0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1, "div_20_m6");
    issue(ALU_REM,  0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'd2, 64, 1, "rem_20_m6");
    issue(ALU_DIVU, 1, 64'h0000_0001_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1, "divuw_1");
    issue(ALU_MULT, 1, 64'h1_0000, 64'h1_0000, 64'd0, 32, 1, "mulw_wrap");
    issue(ALU_DIVU, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, "divu_by0");
    issue(ALU_REMU, 0, 64'd5, 64'd0, 64'd5, 0, 1, "remu_by0");
    issue(ALU_DIV,  0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1, "div_ovf");
    issue(ALU_REM,  0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1, "rem_ovf");
    issue(ALU_DIV,  1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 1, "divw_ovf");
    issue(ALU_DIVU, 0, 64'd100, 64'd7, 64'd14, 64, 1, "divu_100_7");
    issue(ALU_REMU, 0, 64'd100, 64'd7, 64'd2, 64, 1, "remu_100_7");
    issue(ALU_DIV,  1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 1, "divw_m7_2");
    issue(ALU_REM,  1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1, "remw_m7_2");
    issue(ALU_REMU, 1, 64'h0000_0001_8000_0005, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0005, 0, 1, "remuw_by0");
    issue(ALU_DIVU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64, 1, "divu_max_16");
    issue(ALU_REMU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 64, 1, "remu_max_16");
    issue(ALU_MULT, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64, 1, "mul_m1_m1");
    drain("directed");

    // Flush in the middle of a DIV: no done, back to idle, result held.
    snap = done_seen;
    issue(ALU_DIV, 0, 64'd1000, 64'd3, 64'd0, 64, 0, "div_flushed");
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready",  64'(ready), 64'd1);
    chk("flush_busy",   64'(busy),  64'd0);
    chk("flush_result", result,     last_exp);
    repeat (70) @(negedge clk);
    chk("flush_no_done", 64'(done_seen - snap), 64'd0);

    // A flush while idle blocks acceptance.
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; alufunc = ALU_DIVU; a = 64'd9; b = 64'd3;
    @(negedge clk);
    chk("idle_flush_busy", 64'(busy), 64'd0);
    valid = 1'b0; flush = 1'b0;

    // A second request while busy is ignored.
    snap = done_seen;
    issue(ALU_MULT, 0, 64'd3, 64'd5, 64'd15, 64, 1, "mul_3_5");
    repeat (4) @(negedge clk);
    valid = 1'b1; alufunc = ALU_DIVU; a = 64'd100; b = 64'd7;
    repeat (3) @(negedge clk);
    chk("busy_ready", 64'(ready), 64'd0);
    valid = 1'b0;
    drain("busy_req");
    repeat (70) @(negedge clk);
    chk("busy_one_done", 64'(done_seen - snap), 64'd1);

    // Reset in the middle of a MULT.
    snap = done_seen;
    issue(ALU_MULT, 0, 64'd11, 64'd13, 64'd0, 64, 0, "mul_reset");
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ready",  64'(ready), 64'd1);
    chk("midrst_done",   64'(done),  64'd0);
    chk("midrst_result", result,     64'd0);
    repeat (70) @(negedge clk);
    chk("midrst_no_done", 64'(done_seen - snap), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of instruction decode.
- Consumes the decoded ALU function (ALU_MULT, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU) plus the word-op flag for the ALUW op class.
- Produces a 64-bit RV64M result after a multi-cycle operation.
- The execute stage stalls the pipeline while `busy` is high.

Parameters:
- XLEN, 64, operand and result width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid  in  1  request an operation this cycle
- alufunc  in  alu_func_t (pipes enum)  decoded ALU function
- word  in  1  1 = ALUW op class (32-bit op, sign-extended result)
- a  in  64  rs1 operand
- b  in  64  rs2 operand
- flush  in  1  abort any in-flight operation
- ready  out  1  unit idle; request accepted when valid & ready
- busy  out  1  operation in flight (BUSY or DONE state)
- done  out  1  one-cycle pulse: result valid
- result  out  64  final result; held until next accept

Behaviour:
- Reset: state=IDLE, ready=1, busy=0, done=0, result=0, counter=0.
- Accept condition: valid & ready & !flush & alufunc in {MULT, DIV, DIVU, REM, REMU}.
  - Any other alufunc is never accepted; the unit stays IDLE.
- FSM IDLE:
  - On accept, latch a, b, alufunc and word.
  - Set N = 32 if word, else 64.
  - Go to BUSY with counter=N.
  - Exception: a special case (below) goes directly to DONE.
- FSM BUSY:
  - Perform one iteration per cycle, decrementing counter.
  - Multiply: shift-add, 1 bit per cycle.
  - Divide: restoring, 1 quotient bit per cycle, on operand magnitudes.
  - When counter reaches 1 and that iteration completes, go to DONE.
- FSM DONE:
  - done=1 and result valid for exactly one cycle, then IDLE.
  - A new accept is possible in the IDLE cycle that follows.
- Latency:
  - Accept edge to done high: N+1 cycles (65 for 64-bit, 33 for word).
  - Special cases: 1 cycle.
- ready = (state==IDLE); busy = (state!=IDLE).
- Operand preparation in word mode: use a[31:0] and b[31:0].
  - DIV/REM: sign-extend the 32-bit operands.
  - DIVU/REMU: zero-extend the 32-bit operands.
- Final result in word mode: sign-extend the 32-bit result, including DIVUW/REMUW.
- MULT: low XLEN bits of the product (low 32 bits in word mode); signedness is irrelevant.
- Signed divide:
  - Divide magnitudes.
  - Quotient negative iff operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, resolved in IDLE at accept, with no iteration:
  - Divisor zero: quotient = all ones (-1), remainder = dividend (word-truncated then sign-extended in word mode).
  - Signed overflow (dividend = most-negative value for the width, divisor = -1): quotient = dividend, remainder = 0.
- flush:
  - In BUSY or DONE: next state is IDLE, no done pulse (or done suppressed that cycle), result unchanged.
  - In IDLE: blocks acceptance that cycle.
- reset mid-operation: returns to IDLE next edge; all outputs take their reset values.
- valid held high while busy: ignored; not queued.
- Inputs a/b/alufunc may change after acceptance; the latched copies are used.

Test Plan:
- MULT: a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD), word=0 -> done 65 cycles after accept, result=0xFFFF_FFFF_FFFF_FFEB.
- DIV and REM: a=-20, b=6 -> DIV result=-3 (0xFFFF_FFFF_FFFF_FFFD); REM result=-2; each 65 cycles.
- Word ops:
  - DIVU word=1, a=0x0000_0001_FFFF_FFFF, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF (sign-extended 0xFFFFFFFF), done after 33 cycles.
  - MULT word=1, a=0x10000, b=0x10000 -> result=0.
- Divide by zero: DIVU a=5, b=0 -> result=all ones; REMU a=5, b=0 -> result=5. Both done 1 cycle after accept.
- Signed overflow: DIV a=0x8000_0000_0000_0000, b=-1 -> result=0x8000_0000_0000_0000; REM -> 0. Word DIV a=0x8000_0000, b=-1 -> result=0xFFFF_FFFF_8000_0000.
- Abort and back-pressure:
  - flush at cycle 10 of a DIV -> no done pulse, ready=1 next cycle, result retains the previous value.
  - Second request issued while busy -> not accepted.
  - reset asserted mid-MULT -> ready=1, done=0, result=0.
